// File: rtl/crc32_parallel_checker.sv
// -----------------------------------------------------------------------------
// crc32_parallel_checker
//
// Receive-side CRC-32/MPEG-2 checker. Absorbs one byte per clock of a frame
// whose last four bytes are the transmitted CRC (most-significant byte first).
// The running CRC is updated 8 bits per clock with the bitwise MSB-first
// shift/XOR unrolled combinationally. There is no final XOR, so a frame that
// carries its correct CRC leaves a residue of zero. At end of frame the block
// reports pass, CRC error or length error.
//
// Parameters
//   POLY   generator polynomial, non-reflected
//   INIT   value loaded into the CRC register at frame start
//   CNT_W  width of the saturating byte counter
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous, active-high reset
//   load        one-cycle pulse: start a new frame (highest priority)
//   data_valid  crc_in holds a frame byte this cycle
//   d_finish    one-cycle pulse: frame complete, evaluate the check
//   crc_in      received byte, bit 7 processed first
//   busy        high while a frame is being absorbed (RUN)
//   done        high once a result is available (DONE)
//   crc_ok      residue zero and at least 5 bytes absorbed
//   crc_err     residue non-zero and at least 5 bytes absorbed
//   len_err     fewer than 5 bytes absorbed
//   crc_reg     current CRC register value
//   byte_cnt    bytes absorbed in the current frame, saturating
// -----------------------------------------------------------------------------
module crc32_parallel_checker #(
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] INIT  = 32'hFFFFFFFF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             data_valid,
  input  logic             d_finish,
  input  logic [7:0]       crc_in,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [31:0]      crc_reg,
  output logic [CNT_W-1:0] byte_cnt
);

  // A frame must hold at least one payload byte plus the four CRC bytes.
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(5);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      crc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ok_nxt;
  logic             err_nxt;
  logic             len_nxt;

  logic [31:0]      crc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             short_frame;
  logic             residue_zero;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Eight serial MSB-first LFSR steps folded into one combinational update.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[7-i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0000_0000);
    end
    return c;
  endfunction

  // Counter holds at all-ones so a very long frame never wraps to "short".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Byte absorption datapath
  // ---------------------------------------------------------------------------
  // crc_upd / cnt_upd are the values after this cycle's byte (if any). The
  // end-of-frame check looks at these so a byte arriving together with
  // d_finish is counted as the final frame byte.
  always_comb begin
    crc_upd = crc_reg;
    cnt_upd = byte_cnt;
    if (data_valid) begin
      crc_upd = crc_byte(crc_reg, crc_in);
      cnt_upd = sat_inc(byte_cnt);
    end
  end

  assign short_frame  = (cnt_upd < MIN_LEN);
  assign residue_zero = (crc_upd == 32'h0000_0000);

  // ---------------------------------------------------------------------------
  // Next-state and next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_reg;
    cnt_nxt   = byte_cnt;
    ok_nxt    = crc_ok;
    err_nxt   = crc_err;
    len_nxt   = len_err;

    unique case (state)
      IDLE: begin
        // Bytes and finish pulses are meaningless before a frame starts.
        if (load) begin
          state_nxt = RUN;
          crc_nxt   = INIT;
          cnt_nxt   = '0;
          ok_nxt    = 1'b0;
          err_nxt   = 1'b0;
          len_nxt   = 1'b0;
        end
      end

      RUN: begin
        if (load) begin
          // Restart discards the partial frame, including any byte
          // presented in this same cycle; a coincident d_finish is dropped.
          state_nxt = RUN;
          crc_nxt   = INIT;
          cnt_nxt   = '0;
        end else begin
          crc_nxt = crc_upd;
          cnt_nxt = cnt_upd;
          if (d_finish) begin
            state_nxt = DONE;
            len_nxt   = short_frame;
            ok_nxt    = !short_frame && residue_zero;
            err_nxt   = !short_frame && !residue_zero;
          end
        end
      end

      DONE: begin
        // Result is frozen until the next frame is started.
        if (load) begin
          state_nxt = RUN;
          crc_nxt   = INIT;
          cnt_nxt   = '0;
          ok_nxt    = 1'b0;
          err_nxt   = 1'b0;
          len_nxt   = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        crc_nxt   = INIT;
        cnt_nxt   = '0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        len_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      crc_reg  <= INIT;
      byte_cnt <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc_reg  <= crc_nxt;
      byte_cnt <= cnt_nxt;
      crc_ok   <= ok_nxt;
      crc_err  <= err_nxt;
      len_err  <= len_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Result flag invariants
  // ---------------------------------------------------------------------------
  a_flags_onehot_in_done : assert property (
    @(posedge clk) disable iff (rst)
      done |-> $onehot({crc_ok, crc_err, len_err})
  );

  a_flags_clear_outside_done : assert property (
    @(posedge clk) disable iff (rst)
      !done |-> !(crc_ok || crc_err || len_err)
  );

endmodule

// File: tb/tb_crc32_parallel_checker.sv
// -----------------------------------------------------------------------------
// tb_crc32_parallel_checker
//
// Directed bench for crc32_parallel_checker. A table of frames with
// hand-derived results is replayed in a loop; hand-written sequences then
// cover reset, restart/priority, ignore rules and counter saturation.
// A reduced counter width keeps the saturation case short.
// -----------------------------------------------------------------------------
module tb_crc32_parallel_checker;

  localparam int unsigned CNT_W = 6;
  localparam logic [31:0] INIT  = 32'hFFFFFFFF;

  logic             clk;
  logic             rst;
  logic             load;
  logic             data_valid;
  logic             d_finish;
  logic [7:0]       crc_in;
  logic             busy;
  logic             done;
  logic             crc_ok;
  logic             crc_err;
  logic             len_err;
  logic [31:0]      crc_reg;
  logic [CNT_W-1:0] byte_cnt;

  int checks;
  int failures;

  crc32_parallel_checker #(
    .POLY  (32'h04C11DB7),
    .INIT  (INIT),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_valid (data_valid),
    .d_finish   (d_finish),
    .crc_in     (crc_in),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .len_err    (len_err),
    .crc_reg    (crc_reg),
    .byte_cnt   (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bytes are left-aligned in 'bytes': first byte in bits [127:120].
  typedef struct {
    logic [127:0]     bytes;
    int               nbytes;
    bit               fin_with_last;
    bit               exp_ok;
    bit               exp_err;
    bit               exp_len;
    logic [CNT_W-1:0] exp_cnt;
    bit               chk_crc;
    logic [31:0]      exp_crc;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load       = 1'b0;
    data_valid = 1'b0;
    d_finish   = 1'b0;
    crc_in     = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fin);
    crc_in     = b;
    data_valid = 1'b1;
    d_finish   = fin;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_finish();
    d_finish = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    pulse_load();
    chk($sformatf("v%0d_busy_after_load", i), 32'(busy), 32'd1);
    for (int k = 0; k < v.nbytes; k++) begin
      send_byte(v.bytes[127-8*k -: 8], v.fin_with_last && (k == v.nbytes - 1));
    end
    if (!(v.fin_with_last && v.nbytes > 0)) pulse_finish();
    chk($sformatf("v%0d_done", i),    32'(done),     32'd1);
    chk($sformatf("v%0d_busy", i),    32'(busy),     32'd0);
    chk($sformatf("v%0d_crc_ok", i),  32'(crc_ok),   32'(v.exp_ok));
    chk($sformatf("v%0d_crc_err", i), 32'(crc_err),  32'(v.exp_err));
    chk($sformatf("v%0d_len_err", i), 32'(len_err),  32'(v.exp_len));
    chk($sformatf("v%0d_byte_cnt", i), 32'(byte_cnt), 32'(v.exp_cnt));
    if (v.chk_crc) chk($sformatf("v%0d_crc_reg", i), crc_reg, v.exp_crc);
  endtask

  logic [103:0] good_frame;

  initial begin
    checks   = 0;
    failures = 0;
    good_frame = 104'h3132333435363738390376E6E7;

    // bytes, n, fin_with_last, ok, err, len, cnt, chk_crc, crc
    vecs[0] = '{{good_frame, 24'h0}, 13, 1'b0, 1'b1, 1'b0, 1'b0, 6'd13, 1'b1, 32'h00000000};
    vecs[1] = '{{104'h3132333434363738390376E6E7, 24'h0}, 13, 1'b0, 1'b0, 1'b1, 1'b0, 6'd13, 1'b0, 32'h0};
    vecs[2] = '{{good_frame, 24'h0}, 13, 1'b1, 1'b1, 1'b0, 1'b0, 6'd13, 1'b1, 32'h00000000};
    vecs[3] = '{{32'hAA55AA55, 96'h0}, 4, 1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 32'h0};
    vecs[4] = '{128'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{{72'h313233343536373839, 56'h0}, 9, 1'b0, 1'b0, 1'b1, 1'b0, 6'd9, 1'b1, 32'h0376E6E7};
    vecs[6] = '{{40'h3132333435, 88'h0}, 5, 1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 1'b0, 32'h0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_flags",    32'({crc_ok, crc_err, len_err}), 32'd0);
    chk("rst_crc_reg",  crc_reg,       INIT);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Ignore rules in IDLE
    crc_in = 8'h31; data_valid = 1'b1; d_finish = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("idle_ign_busy",  32'(busy),     32'd0);
    chk("idle_ign_done",  32'(done),     32'd0);
    chk("idle_ign_crc",   crc_reg,       INIT);
    chk("idle_ign_cnt",   32'(byte_cnt), 32'd0);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      run_vec(i);
      tick();
    end

    // Bytes and finish in DONE are ignored
    run_vec(0);
    send_byte(8'h55, 1'b1);
    send_byte(8'hA5, 1'b0);
    chk("done_ign_done",   32'(done),     32'd1);
    chk("done_ign_ok",     32'(crc_ok),   32'd1);
    chk("done_ign_crc",    crc_reg,       32'h00000000);
    chk("done_ign_cnt",    32'(byte_cnt), 32'd13);

    // load from DONE clears flags on the same edge
    pulse_load();
    chk("reload_busy",  32'(busy),  32'd1);
    chk("reload_flags", 32'({crc_ok, crc_err, len_err}), 32'd0);

    // Restart mid-frame; the byte presented with load is not absorbed
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    load = 1'b1; crc_in = 8'h34; data_valid = 1'b1;
    tick();
    idle_inputs();
    chk("restart_cnt", 32'(byte_cnt), 32'd0);
    chk("restart_crc", crc_reg,       INIT);
    for (int k = 0; k < 13; k++) send_byte(good_frame[103-8*k -: 8], 1'b0);
    pulse_finish();
    chk("restart_ok",  32'(crc_ok),   32'd1);
    chk("restart_cnt13", 32'(byte_cnt), 32'd13);

    // load coincident with d_finish: restart wins, no result
    pulse_load();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    load = 1'b1; d_finish = 1'b1;
    tick();
    idle_inputs();
    chk("ldfin_busy",  32'(busy),     32'd1);
    chk("ldfin_done",  32'(done),     32'd0);
    chk("ldfin_cnt",   32'(byte_cnt), 32'd0);
    chk("ldfin_crc",   crc_reg,       INIT);
    chk("ldfin_flags", 32'({crc_ok, crc_err, len_err}), 32'd0);

    // Counter saturation: 70 zero bytes on a 6-bit counter. Zero input bytes
    // are an invertible map on a non-zero register, so residue stays non-zero.
    pulse_load();
    for (int k = 0; k < 70; k++) send_byte(8'h00, 1'b0);
    chk("sat_cnt_run", 32'(byte_cnt), 32'd63);
    pulse_finish();
    chk("sat_cnt",     32'(byte_cnt), 32'd63);
    chk("sat_len_err", 32'(len_err),  32'd0);
    chk("sat_crc_err", 32'(crc_err),  32'd1);

    // Asynchronous reset mid-frame, asserted between clock edges
    pulse_load();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy),     32'd0);
    chk("arst_done", 32'(done),     32'd0);
    chk("arst_crc",  crc_reg,       INIT);
    chk("arst_cnt",  32'(byte_cnt), 32'd0);
    tick();
    rst = 1'b0;
    pulse_finish();
    chk("arst_fin_ignored", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
